// File: rtl/ws28xx_frame_sequencer_pkg.sv
// Shared types and default timing for the WS28xx frame sequencer.
// Timing defaults assume a 50 MHz clock.
package ws28xx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } ws28xx_state_t;

  localparam int WS28XX_T_BIT = 62;
  localparam int WS28XX_T_0H  = 20;
  localparam int WS28XX_T_1H  = 40;
  localparam int WS28XX_T_RST = 2500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws28xx_frame_sequencer_if.sv
// Host byte stream into the sequencer. A byte moves on any clock edge where
// byte_valid_i and byte_ready_o are both 1; valid must not wait for ready.
interface ws28xx_frame_sequencer_if;
  logic [7:0] byte_data_i;
  logic       byte_valid_i;
  logic       byte_ready_o;

  modport master (output byte_data_i, output byte_valid_i, input byte_ready_o);
  modport slave  (input byte_data_i, input byte_valid_i, output byte_ready_o);
endinterface

// File: rtl/ws28xx_frame_sequencer_edge_detect.sv
// Registered rising/falling edge pulses of a synchronous level signal.
module edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic pos_edge_o,
  output logic neg_edge_o,
  output logic both_edge_o
);

  logic r_prev;
  logic r_pos;
  logic r_neg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_prev <= 1'b0;
      r_pos  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      r_prev <= sig_i;
      r_pos  <= sig_i & ~r_prev;
      r_neg  <= ~sig_i & r_prev;
    end
  end

  assign pos_edge_o  = r_pos;
  assign neg_edge_o  = r_neg;
  assign both_edge_o = r_pos | r_neg;

endmodule

// File: rtl/ws28xx_frame_sequencer.sv
// WS28xx NRZ serializer with frame sequencing (start, bytes, latch gap).
// Define WS28XX_UNDERRUN_DET_EN to build the sticky underrun_o flag.
module ws28xx_frame_sequencer
  import ws28xx_pkg::*;
#(
  parameter int T_BIT = WS28XX_T_BIT,
  parameter int T_0H  = WS28XX_T_0H,
  parameter int T_1H  = WS28XX_T_1H,
  parameter int T_RST = WS28XX_T_RST
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      frame_sync_i,
  ws28xx_frame_sequencer_if.slave   byte_if,
  output logic                      bit_o,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      underrun_o,
  output ws28xx_state_t             state_o
);

  localparam int CNT_W = $clog2(max_int(T_BIT, T_RST));
  localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] C_T0H      = CNT_W'(T_0H);
  localparam logic [CNT_W-1:0] C_T1H      = CNT_W'(T_1H);
  localparam logic             C_RST_ONE  = (T_RST == 1);

  if (!(T_0H > 0 && T_0H < T_1H && T_1H < T_BIT && T_RST > 0)) begin : g_bad_params
    $error("ws28xx_frame_sequencer: need 0 < T_0H < T_1H < T_BIT and T_RST > 0");
  end

  ws28xx_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             r_end_pending;
  logic             r_start_pending;
  logic             r_bit;
  logic             r_done;

  logic             w_rst_n;
  logic             w_start;
  logic             w_end;
  logic             w_both_edge_unused;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_thr;

  assign w_rst_n = ~rst_i;

  edge_detect u_edge (
    .clk_i       (clk_i),
    .rst_n_i     (w_rst_n),
    .sig_i       (frame_sync_i),
    .pos_edge_o  (w_start),
    .neg_edge_o  (w_end),
    .both_edge_o (w_both_edge_unused)
  );

  assign byte_if.byte_ready_o = ~r_hold_full && (r_state == ARMED || r_state == SHIFT);
  assign w_accept  = byte_if.byte_valid_i & byte_if.byte_ready_o;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_thr     = r_shift[7] ? C_T1H : C_T0H;

`ifdef WS28XX_UNDERRUN_DET_EN
  logic r_underrun;
  assign underrun_o = r_underrun;
`else
  assign underrun_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_hold          <= '0;
      r_hold_full     <= 1'b0;
      r_end_pending   <= 1'b0;
      r_start_pending <= 1'b0;
      r_bit           <= 1'b0;
      r_done          <= 1'b0;
`ifdef WS28XX_UNDERRUN_DET_EN
      r_underrun      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hold      <= byte_if.byte_data_i;
        r_hold_full <= 1'b1;
      end
      if (w_end && (r_state == ARMED || r_state == SHIFT)) r_end_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          r_bit <= 1'b0;
          if (w_start) begin
            r_state <= ARMED;
`ifdef WS28XX_UNDERRUN_DET_EN
            r_underrun <= 1'b0;
`endif
          end
        end

        ARMED: begin
          r_bit <= 1'b0;
          if (r_hold_full) begin
            r_shift     <= r_hold;
            r_hold_full <= 1'b0;
            r_bit_idx   <= 3'd7;
            r_cnt       <= '0;
            r_bit       <= 1'b1;
            r_state     <= SHIFT;
          end else if ((w_end || r_end_pending) && !w_accept) begin
            // A byte landing with the end pulse is sent first; end stays pending.
            r_cnt   <= '0;
            r_done  <= C_RST_ONE;
            r_state <= LATCH;
          end
        end

        SHIFT: begin
          if (r_cnt != C_BIT_LAST) begin
            r_cnt <= w_cnt_inc;
            r_bit <= (w_cnt_inc < w_thr);
          end else if (r_bit_idx != 3'd0) begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_idx <= r_bit_idx - 3'd1;
            r_cnt     <= '0;
            r_bit     <= 1'b1;
          end else if (r_hold_full || w_accept) begin
            // A byte arriving on the final cycle is forwarded without a gap.
            r_shift     <= r_hold_full ? r_hold : byte_if.byte_data_i;
            r_hold_full <= 1'b0;
            r_bit_idx   <= 3'd7;
            r_cnt       <= '0;
            r_bit       <= 1'b1;
          end else if (w_end || r_end_pending) begin
            r_cnt   <= '0;
            r_bit   <= 1'b0;
            r_done  <= C_RST_ONE;
            r_state <= LATCH;
          end else begin
            r_bit   <= 1'b0;
            r_state <= ARMED;
`ifdef WS28XX_UNDERRUN_DET_EN
            r_underrun <= 1'b1;
`endif
          end
        end

        LATCH: begin
          r_bit <= 1'b0;
          if (r_cnt == C_RST_LAST) begin
            r_cnt           <= '0;
            r_end_pending   <= 1'b0;
            r_start_pending <= 1'b0;
            if (r_start_pending || w_start) begin
              r_state <= ARMED;
`ifdef WS28XX_UNDERRUN_DET_EN
              r_underrun <= 1'b0;
`endif
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            r_done <= (w_cnt_inc == C_RST_LAST);
            if (w_start) r_start_pending <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bit_o        = r_bit;
  assign busy_o       = (r_state != IDLE);
  assign frame_done_o = r_done;
  assign state_o      = r_state;

endmodule

// File: tb/tb_ws28xx_frame_sequencer.sv
// Directed bench for ws28xx_frame_sequencer: pulse widths scored against a queue.
module tb_ws28xx_frame_sequencer;
  import ws28xx_pkg::*;

  localparam int TB_T_BIT = 10;
  localparam int TB_T_0H  = 3;
  localparam int TB_T_1H  = 7;
  localparam int TB_T_RST = 20;
`ifdef WS28XX_UNDERRUN_DET_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic frame_sync;
  logic bit_o, busy, frame_done, underrun;
  ws28xx_state_t state;

  ws28xx_frame_sequencer_if bif ();

  ws28xx_frame_sequencer #(
    .T_BIT (TB_T_BIT), .T_0H (TB_T_0H), .T_1H (TB_T_1H), .T_RST (TB_T_RST)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .frame_sync_i (frame_sync),
    .byte_if      (bif),
    .bit_o        (bit_o),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .underrun_o   (underrun),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: each completed high pulse is popped against exp_q.
  int   cyc = 0;
  int   hi_cnt = 0;
  logic prev_bit = 1'b0;
  logic gap_en = 1'b0;
  logic have_prev = 1'b0;
  int   last_rise = 0;
  int   rise_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hi_cnt   = 0;
      prev_bit = 1'b0;
    end else begin
      if (bit_o) begin
        if (!prev_bit && gap_en) begin
          if (have_prev) chk("slot_period", cyc - last_rise, TB_T_BIT);
          last_rise = cyc;
          have_prev = 1'b1;
          rise_cnt++;
        end
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        if (exp_q.size() == 0) chk("pulse_unexpected", hi_cnt, 0);
        else chk("pulse_width", hi_cnt, exp_q.pop_front());
        hi_cnt = 0;
      end
      prev_bit = bit_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input ws28xx_state_t st, input int budget, input string tag);
    int i = 0;
    while (state !== st && i < budget) begin
      tick();
      i++;
    end
    chk(tag, state, st);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    int i = 0;
    for (int k = 7; k >= 0; k--) exp_q.push_back(b[k] ? 8'(TB_T_1H) : 8'(TB_T_0H));
    bif.byte_data_i  = b;
    bif.byte_valid_i = 1'b1;
    while (!bif.byte_ready_o && i < 300) begin
      tick();
      i++;
    end
    chk(tag, bif.byte_ready_o, 1'b1);
    tick();
  endtask

  task automatic frame_rise(input string tag);
    frame_sync = 1'b1;
    wait_state(ARMED, 10, tag);
  endtask

  // Entered on the first LATCH cycle (n0 = LATCH cycles already seen).
  task automatic latch_check(input ws28xx_state_t exp_next, input int n0, input string tag);
    int   n = n0;
    int   highs = 0;
    logic exp_busy;
    exp_busy = (exp_next != IDLE);
    while (!frame_done && n < 100) begin
      tick();
      n++;
      if (bit_o) highs++;
    end
    chk({tag, "_latch_len"}, n, TB_T_RST);
    chk({tag, "_latch_low"}, highs, 0);
    tick();
    chk({tag, "_done_single"}, frame_done, 1'b0);
    chk({tag, "_next_state"}, state, exp_next);
    chk({tag, "_busy_after"}, busy, exp_busy);
  endtask

  initial begin
    int highs;
    rst = 1'b1;
    frame_sync = 1'b0;
    bif.byte_data_i  = 8'h00;
    bif.byte_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bit", bit_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bif.byte_ready_o, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_state", state, IDLE);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Single byte 0xA5.
    frame_rise("t1_armed");
    send_byte(8'hA5, "t1_accept");
    bif.byte_valid_i = 1'b0;
    wait_state(SHIFT, 5, "t1_shift");
    frame_sync = 1'b0;
    wait_state(LATCH, 200, "t1_latch");
    latch_check(IDLE, 1, "t1");

    // 0xFF then 0x00 with valid held: contiguous slots.
    have_prev = 1'b0;
    rise_cnt  = 0;
    gap_en    = 1'b1;
    frame_rise("t2_armed");
    send_byte(8'hFF, "t2_accept_ff");
    chk("t2_ready_full", bif.byte_ready_o, 1'b0);
    send_byte(8'h00, "t2_accept_00");
    bif.byte_valid_i = 1'b0;
    repeat (20) tick();
    chk("t2_ready_held", bif.byte_ready_o, 1'b0);
    frame_sync = 1'b0;
    wait_state(LATCH, 300, "t2_latch");
    gap_en = 1'b0;
    chk("t2_rises", rise_cnt, 16);
    chk("t2_underrun", underrun, 1'b0);
    latch_check(IDLE, 1, "t2");

    // Starvation gap between 0x80 and 0x01.
    frame_rise("t3_armed");
    send_byte(8'h80, "t3_accept_80");
    bif.byte_valid_i = 1'b0;
    wait_state(SHIFT, 5, "t3_shift");
    wait_state(ARMED, 200, "t3_starved");
    chk("t3_underrun_set", underrun, EXP_UR);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bit_o) highs++;
    end
    chk("t3_gap_low", highs, 0);
    send_byte(8'h01, "t3_accept_01");
    bif.byte_valid_i = 1'b0;
    wait_state(SHIFT, 5, "t3_shift2");
    frame_sync = 1'b0;
    wait_state(LATCH, 200, "t3_latch");
    chk("t3_underrun_sticky", underrun, EXP_UR);
    latch_check(IDLE, 1, "t3");

    // Empty frame; underrun clears on rise.
    frame_rise("t4_armed");
    chk("t4_underrun_clr", underrun, 1'b0);
    frame_sync = 1'b0;
    wait_state(LATCH, 10, "t4_latch");
    latch_check(IDLE, 1, "t4");

    // Rising edge during LATCH re-arms straight away.
    frame_rise("t5_armed");
    frame_sync = 1'b0;
    wait_state(LATCH, 10, "t5_latch");
    repeat (5) tick();
    frame_sync = 1'b1;
    latch_check(ARMED, 6, "t5");
    frame_sync = 1'b0;
    wait_state(LATCH, 10, "t5_latch2");
    latch_check(IDLE, 1, "t5b");

    // Reset during a high phase.
    frame_rise("t6_armed");
    send_byte(8'hFF, "t6_accept");
    bif.byte_valid_i = 1'b0;
    wait_state(SHIFT, 5, "t6_shift");
    repeat (23) tick();
    chk("t6_pre_high", bit_o, 1'b1);
    frame_sync = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_bit", bit_o, 1'b0);
    chk("t6_rst_ready", bif.byte_ready_o, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bit_o || state != IDLE) highs++;
    end
    chk("t6_quiet", highs, 0);
    frame_rise("t6_rearm");
    send_byte(8'h3C, "t6_accept2");
    bif.byte_valid_i = 1'b0;
    wait_state(SHIFT, 5, "t6_shift2");
    frame_sync = 1'b0;
    wait_state(LATCH, 200, "t6_latch");
    latch_check(IDLE, 1, "t6");

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ws28xx_frame_sequencer.md
# ws28xx_frame_sequencer

Serializes host pixel bytes into the single-wire WS28xx NRZ waveform and sequences each frame. A frame runs from start, through back-to-back bytes, to the latch (reset) gap. Frame boundaries come from a level strobe `frame_sync_i`, converted to one-cycle start/end events by an internal `edge_detect` instance. The block sits between the host byte interface (SPI/FIFO side) and the LED data pin.

## Interface
- `T_BIT`, default 62: bit period in `clk_i` cycles (1.25 us at 50 MHz).
- `T_0H`, default 20: high time of a 0 bit, in cycles.
- `T_1H`, default 40: high time of a 1 bit, in cycles.
- `T_RST`, default 2500: latch gap in cycles (50 us).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `frame_sync_i`  in  1  frame strobe, synchronous to `clk_i`. Rising edge = frame start; falling edge = frame end.
- `byte_data_i`  in  8  pixel byte, sent MSB first.
- `byte_valid_i`  in  1  byte available.
- `byte_ready_o`  out  1  holding register empty; the byte transfers when valid and ready are both 1.
- `bit_o`  out  1  LED data line.
- `busy_o`  out  1  high in every state except IDLE.
- `frame_done_o`  out  1  one-cycle pulse on the last cycle of the latch gap.
- `underrun_o`  out  1  sticky; byte starvation occurred inside the current frame.

## Operation
- Reset values: every output is 0; state IDLE; holding register empty; `end_pending` and `start_pending` are 0.
- Datapath:
  - One 8-bit holding register plus an 8-bit shift register.
  - `byte_ready_o` = holding register empty AND state in {ARMED, SHIFT}. It has no combinational path from `byte_valid_i`.
- States and transitions:
  - IDLE:
    - `bit_o` = 0.
    - A start pulse moves to ARMED and clears `underrun_o`.
  - ARMED:
    - `bit_o` = 0.
    - If the holding register is full, move it to the shift register, set `bit_idx` = 7 and `cnt` = 0, and go to SHIFT.
    - Otherwise, if an end pulse occurs or `end_pending` = 1, go to LATCH. An empty frame is legal.
  - SHIFT:
    - `cnt` counts 0 to `T_BIT-1`.
    - `bit_o` = (`cnt` < (current bit ? `T_1H` : `T_0H`)).
    - An end pulse sets `end_pending`.
    - At `cnt` = `T_BIT-1` with `bit_idx` > 0: shift left, decrement `bit_idx`, and set `cnt` = 0.
    - At `cnt` = `T_BIT-1` with `bit_idx` = 0:
      - Holding register full: reload and continue with no idle cycle.
      - Otherwise, `end_pending` = 1 or an end pulse this cycle: go to LATCH.
      - Otherwise: go to ARMED and set `underrun_o`.
  - LATCH:
    - `bit_o` = 0 for exactly `T_RST` cycles.
    - On the last cycle, pulse `frame_done_o`, clear `end_pending`, and go to ARMED if `start_pending` = 1, else IDLE.
    - A start pulse in LATCH sets `start_pending`, which clears on exit.
- Boundary cases:
  - A start pulse while in ARMED or SHIFT is ignored.
  - An end pulse in IDLE is ignored.
  - Bytes already accepted before the end pulse are always transmitted before LATCH.
- Reset mid-operation: `bit_o` falls to 0 immediately (asynchronous); the pending byte is discarded.
- Width rules:
  - `cnt` width is `$clog2(max(T_BIT, T_RST))`.
  - Parameters must satisfy 0 < `T_0H` < `T_1H` < `T_BIT`.
  - A violation fails elaboration via a `$error` assertion.

## Timing
- Start latency: ARMED is entered 2 cycles after `frame_sync_i` is first sampled high (1 cycle for `edge_detect`, 1 for the FSM). End latency is the same.
- First bit: `bit_o` rises on the cycle after ARMED sees the holding register full.
- Bit streams within a frame are gap-free as long as each next byte is accepted before `cnt` = `T_BIT-1` of bit 0.
- Byte N+1 may be accepted from the cycle after byte N moves into the shift register.
- `frame_done_o` fires `T_RST` cycles after the last bit ends.

## Configuration
- Macro: `WS28XX_UNDERRUN_DET_EN`.
- Defined: `underrun_o` is implemented as described above (set on the starvation transition SHIFT to ARMED, cleared on frame start).
- Undefined: no flag logic is built; `underrun_o` is tied to 0. All other behaviour is identical.

## Structure
- Package `ws28xx_pkg` holds:
  - the state enum `ws28xx_state_t` (IDLE, ARMED, SHIFT, LATCH);
  - default timing constants `WS28XX_T_BIT`, `WS28XX_T_0H`, `WS28XX_T_1H`, `WS28XX_T_RST`.
- Sub-module: the existing `edge_detect` on `frame_sync_i`, with `rst_n_i` driven by `~rst_i`.
  - `pos_edge_o` is the start pulse and `neg_edge_o` the end pulse.
  - `both_edge_o` is left unconnected.

## Test plan
Bench parameters: `T_BIT`=10, `T_0H`=3, `T_1H`=7, `T_RST`=20.
- Single byte 0xA5 in one frame -> `bit_o` high-time pattern 7,3,7,3,3,7,3,7 per 10-cycle slot (80 cycles total), then 20 cycles low, `frame_done_o` pulses once, state returns to IDLE.
- Bytes 0xFF,0x00 with `byte_valid_i` held high -> 160 contiguous cycles with no extra low cycle between bytes; `byte_ready_o` = 0 while the holding register is full; `underrun_o` = 0.
- Byte 0x80, then 0x01 presented 30 cycles later, then end -> line low during the gap; `underrun_o` = 1 (0 when the macro is undefined); it clears on the next frame rise.
- Rise then fall of `frame_sync_i` with no bytes -> `bit_o` never high; `frame_done_o` pulses 20 cycles after LATCH entry.
- Rising edge of `frame_sync_i` during LATCH -> `frame_done_o` pulses, then state is ARMED on the next cycle and `busy_o` stays 1.
- Assert `rst_i` during a high phase (with `frame_sync_i` low) -> `bit_o`, `byte_ready_o` and `busy_o` are 0 immediately; no transmission until a new rising edge.
